// File: rtl/bitstream_feeder_pkg.sv
// Shared types and constants for the bitstream word feeder.
package bitstream_feeder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } feeder_state_e;

endpackage

// File: rtl/bitstream_byte_packer.sv
// Big-endian byte-to-word packer: first byte of a word lands in the MSB,
// unfilled low bytes stay zero when a word is closed early by last_in.
module bitstream_byte_packer
  import bitstream_feeder_pkg::*;
(
  input  logic              CLK,
  input  logic              resetn,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  input  logic              last_in,
  output logic [WORD_W-1:0] word_o,
  output logic              complete_o
);

  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] placed;

  always_comb begin
    placed     = {byte_in, {(WORD_W-8){1'b0}}} >> {idx_q, 3'b000};
    word_o     = acc_q | placed;
    complete_o = accept & (last_in | (idx_q == 2'd3));
    idx_d      = idx_q;
    acc_d      = acc_q;
    // A closed word hands off via word_o, so the accumulator restarts empty.
    if (clear || complete_o) begin
      idx_d = '0;
      acc_d = '0;
    end else if (accept) begin
      idx_d = idx_q + 2'd1;
      acc_d = word_o;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/bitstream_word_feeder.sv
// Packs a byte stream into 32-bit words and writes them with setup/strobe/hold pacing.
// Optional first-word sync check enabled by defining FEEDER_SYNC_CHECK_EN.
module bitstream_word_feeder
  import bitstream_feeder_pkg::*;
#(
  parameter int unsigned        SETUP_CYCLES = 2,
  parameter int unsigned        HOLD_CYCLES  = 2,
  parameter int unsigned        MAX_BYTES    = 16384,
  parameter logic [WORD_W-1:0]  SYNC_WORD    = DEFAULT_SYNC_WORD
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] SelfWriteData,
  output logic              SelfWriteStrobe,
  output logic              busy,
  output logic              done,
  output logic [12:0]       words_written,
  output logic              sync_err
);

`ifdef FEEDER_SYNC_CHECK_EN
  localparam bit SyncCheck = 1'b1;
`else
  localparam bit SyncCheck = 1'b0;
`endif

  localparam int unsigned BC_W = $clog2(MAX_BYTES + 1);

  feeder_state_e     state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic              final_q, final_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [12:0]       words_q, words_d;
  logic              sync_err_q, sync_err_d;

  logic              accept;
  logic              load_start;
  logic [WORD_W-1:0] pk_word;
  logic              pk_complete;

  assign accept     = (state_q == S_COLLECT) & in_valid;
  assign load_start = start & ((state_q == S_IDLE) | (state_q == S_DONE));

  bitstream_byte_packer u_packer (
    .CLK        (CLK),
    .resetn     (resetn),
    .clear      (load_start),
    .accept     (accept),
    .byte_in    (in_data),
    .last_in    (in_last),
    .word_o     (pk_word),
    .complete_o (pk_complete)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    final_d    = final_q;
    data_d     = data_q;
    words_d    = words_q;
    sync_err_d = sync_err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_COLLECT;
          byte_cnt_d = '0;
          words_d    = '0;
          final_d    = 1'b0;
          sync_err_d = 1'b0;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (pk_complete) begin
            // MAX_BYTES is a word multiple, so the cap always coincides with a word close.
            final_d = in_last | (byte_cnt_q == BC_W'(MAX_BYTES - 1));
            cnt_d   = '0;
            if (SyncCheck && (words_q == '0) && (pk_word != SYNC_WORD)) begin
              sync_err_d = 1'b1;
              state_d    = S_DONE;
            end else begin
              data_d  = pk_word;
              state_d = S_SETUP;
            end
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == 16'(SETUP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STROBE: begin
        words_d = words_q + 13'd1;
        if (HOLD_CYCLES == 0) state_d = final_q ? S_DONE : S_COLLECT;
        else                  state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == 16'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = final_q ? S_DONE : S_COLLECT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      final_q    <= 1'b0;
      data_q     <= '0;
      words_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      final_q    <= final_d;
      data_q     <= data_d;
      words_q    <= words_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign in_ready        = (state_q == S_COLLECT);
  assign SelfWriteStrobe = (state_q == S_STROBE);
  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done            = (state_q == S_DONE);
  assign SelfWriteData   = data_q;
  assign words_written   = words_q;
  assign sync_err        = SyncCheck ? sync_err_q : 1'b0;

endmodule

// File: tb/tb_bitstream_word_feeder.sv
// Randomized self-checking bench for bitstream_word_feeder (default and MAX_BYTES=8 instances).
module tb_bitstream_word_feeder;

  localparam int S = 2;
  localparam int H = 2;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
`ifdef FEEDER_SYNC_CHECK_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       start_m8 = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;

  logic        rdy_a, stb_a, busy_a, done_a, serr_a;
  logic [31:0] data_a;
  logic [12:0] words_a;
  logic        rdy_b, stb_b, busy_b, done_b, serr_b;
  logic [31:0] data_b;
  logic [12:0] words_b;

  always #5 CLK = ~CLK;

  bitstream_word_feeder dut (
    .CLK(CLK), .resetn(resetn), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy_a), .SelfWriteData(data_a), .SelfWriteStrobe(stb_a),
    .busy(busy_a), .done(done_a), .words_written(words_a), .sync_err(serr_a)
  );

  bitstream_word_feeder #(.MAX_BYTES(8)) dut_m8 (
    .CLK(CLK), .resetn(resetn), .start(start_m8), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy_b), .SelfWriteData(data_b), .SelfWriteStrobe(stb_b),
    .busy(busy_b), .done(done_b), .words_written(words_b), .sync_err(serr_b)
  );

  bit          sel = 1'b0;
  logic        o_rdy, o_stb, o_busy, o_done, o_serr;
  logic [31:0] o_data;
  logic [12:0] o_words;

  always_comb begin
    if (sel) begin
      o_rdy = rdy_b; o_stb = stb_b; o_busy = busy_b; o_done = done_b;
      o_serr = serr_b; o_data = data_b; o_words = words_b;
    end else begin
      o_rdy = rdy_a; o_stb = stb_a; o_busy = busy_a; o_done = done_a;
      o_serr = serr_a; o_data = data_a; o_words = words_a;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: accepted bytes of the open word, and the timing window of the last closed word.
  logic [7:0]  pend[$];
  logic [7:0]  stim[$];
  int          since_close = -1;
  logic [31:0] cur_exp = 32'h0;
  bit          cur_final = 1'b0;
  bit          load_over = 1'b0;
  bit          aborted = 1'b0;
  bit          abort_chk = 1'b0;
  int          load_bytes = 0;
  int          words_in_load = 0;
  int          model_max = 16384;
  int          strobes_seen = 0;
  int          cyc = 0;
  int          last_stb = -1;
  bit          chk_spacing = 1'b0;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    if (abort_chk) begin
      check("sync_abort_done", o_done, 1);
      check("sync_abort_err", o_serr, 1);
      check("sync_abort_rdy", o_rdy, 0);
      abort_chk = 1'b0;
    end
    if (o_stb) begin
      strobes_seen++;
      if (chk_spacing && last_stb >= 0) check("strobe_spacing", cyc - last_stb, 9);
      last_stb = cyc;
    end
    if (since_close >= 0) begin
      since_close++;
      check("data_window", o_data, cur_exp);
      if (since_close <= 1 + S + H) begin
        check("rdy_low", o_rdy, 0);
        check("strobe_timing", o_stb, since_close == 1 + S);
        check("busy_window", o_busy, 1);
      end else begin
        check("rdy_resume", o_rdy, !cur_final);
        check("done_rise", o_done, cur_final);
        since_close = -1;
      end
    end else begin
      check("no_stray_strobe", o_stb, 0);
    end
  endtask

  task automatic close_word(input bit last);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++) w = {w[23:0], (i < pend.size()) ? pend[i] : 8'h00};
    pend.delete();
    if (SYNC_EN && words_in_load == 0 && w != SYNC) begin
      abort_chk = 1'b1;
      aborted   = 1'b1;
      load_over = 1'b1;
    end else begin
      cur_exp     = w;
      cur_final   = last || (load_bytes == model_max);
      since_close = 0;
      words_in_load++;
      if (cur_final) load_over = 1'b1;
    end
  endtask

  task automatic send(input bit term, input bit gaps);
    int waited;
    bit acc;
    for (int i = 0; i < stim.size() && !load_over; i++) begin
      waited = 0;
      acc = 1'b0;
      while (!acc) begin
        in_data  = stim[i];
        in_last  = term && (i == stim.size() - 1);
        in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        acc = in_valid && o_rdy;
        if (acc) begin
          pend.push_back(stim[i]);
          load_bytes++;
          if (pend.size() == 4 || in_last || load_bytes == model_max) close_word(in_last);
        end
        tick();
        waited++;
        if (!acc && waited > 100) begin
          check("accept_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    waited = 0;
    while ((since_close >= 0 || abort_chk) && waited < 50) begin
      tick();
      waited++;
    end
  endtask

  task automatic begin_load(input bit use_m8);
    sel = use_m8;
    model_max = use_m8 ? 8 : 16384;
    load_bytes = 0; words_in_load = 0; load_over = 1'b0; aborted = 1'b0;
    pend.delete(); strobes_seen = 0; last_stb = -1; since_close = -1;
    if (use_m8) start_m8 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start_m8 = 1'b0;
    check("start_busy", o_busy, 1);
    check("start_done_clr", o_done, 0);
    check("start_words_clr", o_words, 0);
    check("start_serr_clr", o_serr, 0);
    check("start_rdy", o_rdy, 1);
  endtask

  task automatic end_load_checks();
    check("words_written", o_words, words_in_load);
    check("strobe_count", strobes_seen, words_in_load);
    check("done_final", o_done, load_over);
    check("sync_err_final", o_serr, aborted);
  endtask

  task automatic push_sync();
    stim.push_back(8'hFA); stim.push_back(8'hB0); stim.push_back(8'hFA); stim.push_back(8'hB1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_data", o_data, 0);
    check("rst_strobe", o_stb, 0);
    check("rst_rdy", o_rdy, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_words", o_words, 0);
    check("rst_serr", o_serr, 0);
    resetn = 1'b1;
    @(negedge CLK);

    // Sequential bytes 00..0F, no stalls.
    begin_load(0);
    chk_spacing = 1'b1;
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(8'(i));
    send(1, 0);
    chk_spacing = 1'b0;
    end_load_checks();

    // Short tail word, zero padded.
    begin_load(0);
    stim.delete();
    stim.push_back(8'hAA); stim.push_back(8'hBB); stim.push_back(8'hCC);
    send(1, 0);
    end_load_checks();

    // 64 random bytes with random valid gaps.
    begin_load(0);
    stim.delete();
    push_sync();
    for (int i = 0; i < 60; i++) stim.push_back(8'($urandom));
    send(1, 1);
    end_load_checks();

    // Reset during SETUP of the second word.
    begin_load(0);
    stim.delete();
    push_sync();
    send(0, 0);
    check("pre_rst_words", o_words, 1);
    stim.delete();
    stim.push_back(8'h11); stim.push_back(8'h22); stim.push_back(8'h33);
    send(0, 0);
    in_data = 8'h44; in_valid = 1'b1; in_last = 1'b0;
    check("pre_rst_rdy", o_rdy, 1);
    tick();
    in_valid = 1'b0;
    check("setup_busy", o_busy, 1);
    resetn = 1'b0;
    #1;
    check("abort_data", o_data, 0);
    check("abort_strobe", o_stb, 0);
    check("abort_busy", o_busy, 0);
    check("abort_rdy", o_rdy, 0);
    check("abort_words", o_words, 0);
    pend.delete();
    since_close = -1;
    repeat (6) tick();
    resetn = 1'b1;
    tick();
    begin_load(0);
    stim.delete();
    push_sync();
    stim.push_back(8'h01); stim.push_back(8'h02); stim.push_back(8'h03); stim.push_back(8'h04);
    send(1, 0);
    end_load_checks();

    // First word not equal to the sync word.
    begin_load(0);
    stim.delete();
    stim.push_back(8'h12); stim.push_back(8'h34); stim.push_back(8'h56); stim.push_back(8'h78);
    send(1, 0);
    end_load_checks();

    // MAX_BYTES=8 instance with an unterminated stream.
    begin_load(1);
    stim.delete();
    push_sync();
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    send(0, 0);
    end_load_checks();
    check("m8_words", o_words, 2);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (5) begin
      tick();
      check("m8_rdy_low", o_rdy, 0);
      check("m8_done_held", o_done, 1);
    end
    in_valid = 1'b0;
    check("m8_words_final", o_words, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
